paper_sequencer_param: RTL

- Parametrised successor to the paper processor's control counters: generates stateCount (instruction phase), programCount (PC) and registerCount (destination register index) for a multicycle paper CPU.
- New over the previous generation: widths and depths are configurable, plus single-step mode, deferred jump load, halt/resume, and completion/wrap pulses.
- Sits between the top-level clock/enable and the datapath; its counters drive the phase decode and the register file index.

---
 rtl/paper_pkg.sv | 30 +++
 rtl/paper_mod_counter.sv | 38 +++
 rtl/paper_sequencer_param.sv | 117 +++++++++++
 3 files changed

// File: rtl/paper_pkg.sv
// Shared types and default sizes for the paper CPU sequencer.
package paper_pkg;

  // Instruction phases for the default four-phase decode.
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } phase_e;

  // Control FSM: RUN advances counters, HALT freezes them until resume.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ctrl_e;

  localparam int DEF_REG_W      = 3;
  localparam int DEF_REG_COUNT  = 8;
  localparam int DEF_PC_W       = 2;
  localparam int DEF_PROG_DEPTH = 4;
  localparam int DEF_ST_W       = 2;
  localparam int DEF_NUM_STATES = 4;

  // True when a modulus is non-zero and representable in the given width.
  function automatic bit fits(input int modulus, input int width);
    return (modulus >= 1) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/paper_mod_counter.sv
// Modulo-MOD up counter with an optional load. wrap is combinational and
// flags that the current enabled increment rolls MOD-1 back to 0.
module paper_mod_counter
  import paper_pkg::*;
#(
  parameter int W   = 2,
  parameter int MOD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  if (!fits(MOD, W)) begin : g_bad_mod
    $error("paper_mod_counter: MOD %0d does not fit in %0d bits", MOD, W);
  end

  // A load takes the place of the increment, so it never reports a wrap.
  assign wrap = en & ~load & (q == LAST);

  // Count state: load has priority over the modulo increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= (q == LAST) ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/paper_sequencer_param.sv
// Phase / PC / register-index sequencer for the multicycle paper CPU.
// Handshake note: jump_valid/jump_addr is a fire-and-forget request with no
// ready; an in-range request is captured the cycle it is high (latest wins)
// and applied at the next instruction boundary, out-of-range ones are dropped.
module paper_sequencer_param
  import paper_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int REG_COUNT    = DEF_REG_COUNT,
  parameter int PC_W         = DEF_PC_W,
  parameter int PROG_DEPTH   = DEF_PROG_DEPTH,
  parameter int ST_W         = DEF_ST_W,
  parameter int NUM_STATES   = DEF_NUM_STATES,
  parameter int HALT_ON_WRAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             step_mode,
  input  logic             step,
  input  logic             jump_valid,
  input  logic [PC_W-1:0]  jump_addr,
  input  logic             resume,
  output logic [REG_W-1:0] registerCount,
  output logic [PC_W-1:0]  programCount,
  output logic [ST_W-1:0]  stateCount,
  output logic             instr_done,
  output logic             pc_wrap,
  output logic             halted
);

  if (NUM_STATES < 2) begin : g_bad_states
    $error("paper_sequencer_param: NUM_STATES must be at least 2");
  end

  localparam logic [PC_W:0] DEPTH = (PC_W + 1)'(PROG_DEPTH);

  ctrl_e           ctrl;
  logic            pend_v;
  logic [PC_W-1:0] pend_a;
  logic            adv;
  logic            boundary;
  logic            pc_wrap_now;
  logic            reg_wrap_unused;
  logic            jump_ok;
  logic            take_jump;
  logic [PC_W-1:0] jump_tgt;

  assign jump_ok   = jump_valid & ({1'b0, jump_addr} < DEPTH);
  assign adv       = clk_en & (ctrl == RUN) & (step_mode ? step : 1'b1);
  // A same-cycle request bypasses whatever is pending.
  assign take_jump = boundary & (jump_ok | pend_v);
  assign jump_tgt  = jump_ok ? jump_addr : pend_a;

  // Phase counter; its wrap marks the instruction boundary.
  paper_mod_counter #(.W(ST_W), .MOD(NUM_STATES)) u_state (
    .clk(clk), .reset(reset), .en(adv), .load(1'b0), .d('0),
    .q(stateCount), .wrap(boundary)
  );

  // Program counter: increments at the boundary unless a jump is taken.
  paper_mod_counter #(.W(PC_W), .MOD(PROG_DEPTH)) u_pc (
    .clk(clk), .reset(reset), .en(boundary), .load(take_jump), .d(jump_tgt),
    .q(programCount), .wrap(pc_wrap_now)
  );

  // Destination register index, one step per retired instruction.
  paper_mod_counter #(.W(REG_W), .MOD(REG_COUNT)) u_reg (
    .clk(clk), .reset(reset), .en(boundary), .load(1'b0), .d('0),
    .q(registerCount), .wrap(reg_wrap_unused)
  );

  // Pending jump latch: live regardless of clk_en or HALT, cleared on use.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v <= 1'b0;
      pend_a <= '0;
    end else if (take_jump) begin
      pend_v <= 1'b0;
    end else if (jump_ok) begin
      pend_v <= 1'b1;
      pend_a <= jump_addr;
    end
  end

  // Control FSM with registered retire/wrap pulses and halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl       <= RUN;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      pc_wrap    <= 1'b0;
    end else begin
      instr_done <= boundary;
      pc_wrap    <= pc_wrap_now;
      case (ctrl)
        RUN: begin
          if ((HALT_ON_WRAP != 0) && pc_wrap_now) begin
            ctrl   <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            ctrl   <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          ctrl   <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
